// File: rtl/ndma_xfer_feeder.sv
// NanoDMA feeder: one-outstanding OBI reads into a FIFO, one write request per word; first write ~4 cycles after start.
// Backpressure: reads stall at FIFO_DEPTH buffered+outstanding, writes wait on wr_busy_i. Read-error handling under NDMA_FEEDER_ERR_EN.
module ndma_xfer_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_req_o,
    output logic [31:0]      rd_addr_o,
    input  logic             rd_gnt_i,
    input  logic             rd_rvalid_i,
    input  logic [31:0]      rd_rdata_i,
    output logic             wr_req_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_wdata_o,
`ifdef NDMA_FEEDER_ERR_EN
    input  logic             rd_err_i,
    output logic             err_o,
`endif
    input  logic             wr_busy_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_BUSY} wr_state_t;

    rd_state_t        rd_state, rd_next;
    wr_state_t        wr_state, wr_next;
    logic [31:0]      src, dst;
    logic [LEN_W-1:0] len, rd_cnt, wr_cnt;
    logic             busy, done;
    logic             start_ok, rd_issue, push, pop, resp_err, err, wr_last, err_end, finish;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_count;

    function automatic logic [31:0] word_off(input logic [LEN_W-1:0] c);
        return 32'(c) << 2;
    endfunction

    assign start_ok = start_i && !busy;

`ifdef NDMA_FEEDER_ERR_EN
    assign resp_err = rd_err_i;
    assign err_o    = err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err <= 1'b0;
        else if (start_ok)
            err <= 1'b0;
        else if (rd_state == R_RESP && rd_rvalid_i && rd_err_i)
            err <= 1'b1;
    end
`else
    assign resp_err = 1'b0;
    assign err      = 1'b0;
`endif

    assign push = (rd_state == R_RESP) && rd_rvalid_i && !resp_err;
    assign pop  = (wr_state == W_REQ);

    // Issue is only evaluated in R_IDLE, where nothing is outstanding, so the count alone bounds occupancy.
    assign rd_issue = busy && !err && (rd_cnt < len) && (int'(fifo_count) < FIFO_DEPTH);

    assign wr_last = (wr_state == W_BUSY) && !wr_busy_i && (wr_cnt == len);
    assign err_end = err && (rd_state == R_IDLE) && (wr_state == W_IDLE) && (fifo_count == '0);
    assign finish  = busy && (wr_last || err_end);

    // Data buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= rd_rdata_i;
    end

    // Job registers and counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                src    <= src_addr_i;
                dst    <= dst_addr_i;
                len    <= len_i;
                rd_cnt <= '0;
                wr_cnt <= '0;
                busy   <= (len_i != '0);
                done   <= (len_i == '0);
            end else begin
                if (finish) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (rd_state == R_REQ && rd_gnt_i) rd_cnt <= rd_cnt + LEN_W'(1);
                if (pop)                          wr_cnt <= wr_cnt + LEN_W'(1);
            end
        end
    end

    assign busy_o = busy;
    assign done_o = done;

    // Read FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_issue)    rd_next = R_REQ;
            R_REQ:   if (rd_gnt_i)    rd_next = R_RESP;
            R_RESP:  if (rd_rvalid_i) rd_next = R_IDLE;
            default:                  rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_req_o  = 1'b0;
        rd_addr_o = '0;
        if (rd_state == R_REQ) begin
            rd_req_o  = 1'b1;
            rd_addr_o = src + word_off(rd_cnt);
        end
    end

    // Write FSM; wr_req_o comes from state only since the manager's busy follows our req.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (fifo_count != '0 && !wr_busy_i) wr_next = W_REQ;
            W_REQ:                                       wr_next = W_BUSY;
            W_BUSY:  if (!wr_busy_i)                     wr_next = W_IDLE;
            default:                                     wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        wr_req_o   = 1'b0;
        wr_addr_o  = '0;
        wr_wdata_o = '0;
        if (wr_state == W_REQ) begin
            wr_req_o   = 1'b1;
            wr_addr_o  = dst + word_off(wr_cnt);
            wr_wdata_o = mem[rd_ptr];
        end
    end
endmodule
